// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver configuration path.
// Holds the controller FSM encoding, grant tags, error codes and config addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2,
    GNT_REC  = 2'd3
  } grant_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic [3:0] CFG_ADDR_PARITY = 4'b0101;
  localparam logic [3:0] CFG_ADDR_STOP   = 4'b0110;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_err_monitor.sv
// Tracks total and consecutive errored UART frames and raises a recovery
// request once a run of consecutive errors reaches the threshold.
module uart_err_monitor
  import uart_pkg::*;
#(
  parameter int ERR_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] error,
  input  logic       valid_error,
  input  logic       valid_out,
  input  logic       rec_clear,
  output logic [7:0] err_count,
  output logic       rec_pending
);

  logic       err_hit;
  logic [3:0] consec;
  logic [3:0] consec_inc;
  logic       rec_fire;

  assign err_hit    = valid_error && (error != ERR_NONE);
  assign consec_inc = (consec == 4'hf) ? consec : consec + 4'd1;
  // While a recovery is pending, further runs keep counting but cannot re-arm it.
  assign rec_fire   = err_hit && !rec_pending && (consec_inc >= 4'(ERR_THRESH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count   <= 8'd0;
      consec      <= 4'd0;
      rec_pending <= 1'b0;
    end else begin
      if (err_hit) begin
        err_count <= sat_inc8(err_count);
      end
      // An error in the same cycle as a good byte takes precedence.
      if (rec_fire) begin
        consec <= 4'd0;
      end else if (err_hit) begin
        consec <= consec_inc;
      end else if (valid_out) begin
        consec <= 4'd0;
      end
      if (rec_fire) begin
        rec_pending <= 1'b1;
      end else if (rec_clear) begin
        rec_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_cfg_ctrl.sv
// Arbitrates host (A) and debug (B) config writes plus automatic recovery
// writes onto the UART's single c_valid/c_ready configuration port.
module uart_cfg_ctrl
  import uart_pkg::*;
#(
  parameter int         ERR_THRESH = 4,
  parameter logic [3:0] REC_ADDR   = 4'b0101,
  parameter logic [7:0] REC_DATA   = 8'h00,
  parameter int         TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       resp_err,
  output logic       c_valid,
  output logic [3:0] c_addr,
  output logic [7:0] c_data,
  input  logic       c_ready,
  input  logic [1:0] error,
  input  logic       valid_error,
  input  logic       valid_out,
  output logic [7:0] err_count,
  output logic       recovery_active,
  output logic       busy
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  // Handshakes: a/b_valid with addr/data are held until the one-cycle
  // a/b_ready pulse in ACK; c_valid/c_addr/c_data are held until c_ready is
  // sampled high with c_valid, or until TIMEOUT cycles elapse (abort).
  state_t            state, state_nxt;
  grant_t            grant, grant_nxt;
  logic              abort, abort_nxt;
  logic              rr_b, rr_b_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              c_valid_nxt;
  logic [3:0]        c_addr_nxt;
  logic [7:0]        c_data_nxt;
  logic              rec_pending;
  logic              rec_clear;

  uart_err_monitor #(
    .ERR_THRESH (ERR_THRESH)
  ) u_err_monitor (
    .clk         (clk),
    .rst         (rst),
    .error       (error),
    .valid_error (valid_error),
    .valid_out   (valid_out),
    .rec_clear   (rec_clear),
    .err_count   (err_count),
    .rec_pending (rec_pending)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant    <= GNT_NONE;
      abort    <= 1'b0;
      rr_b     <= 1'b0;
      wait_cnt <= '0;
      c_valid  <= 1'b0;
      c_addr   <= 4'd0;
      c_data   <= 8'd0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      abort    <= abort_nxt;
      rr_b     <= rr_b_nxt;
      wait_cnt <= wait_cnt_nxt;
      c_valid  <= c_valid_nxt;
      c_addr   <= c_addr_nxt;
      c_data   <= c_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    abort_nxt    = abort;
    rr_b_nxt     = rr_b;
    wait_cnt_nxt = wait_cnt;
    c_valid_nxt  = c_valid;
    c_addr_nxt   = c_addr;
    c_data_nxt   = c_data;
    case (state)
      ST_IDLE: begin
        wait_cnt_nxt = '0;
        abort_nxt    = 1'b0;
        if (rec_pending) begin
          grant_nxt   = GNT_REC;
          c_valid_nxt = 1'b1;
          c_addr_nxt  = REC_ADDR;
          c_data_nxt  = REC_DATA;
          state_nxt   = ST_ISSUE;
        end else if (a_valid && (!b_valid || !rr_b)) begin
          // rr_b set means B was not served last and wins a tie.
          grant_nxt   = GNT_A;
          rr_b_nxt    = 1'b1;
          c_valid_nxt = 1'b1;
          c_addr_nxt  = a_addr;
          c_data_nxt  = a_data;
          state_nxt   = ST_ISSUE;
        end else if (b_valid) begin
          grant_nxt   = GNT_B;
          rr_b_nxt    = 1'b0;
          c_valid_nxt = 1'b1;
          c_addr_nxt  = b_addr;
          c_data_nxt  = b_data;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (c_ready) begin
          c_valid_nxt = 1'b0;
          state_nxt   = ST_ACK;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          c_valid_nxt = 1'b0;
          abort_nxt   = 1'b1;
          state_nxt   = ST_ACK;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ST_ACK: begin
        grant_nxt = GNT_NONE;
        state_nxt = ST_IDLE;
      end
      default: begin
        grant_nxt   = GNT_NONE;
        c_valid_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  assign a_ready         = (state == ST_ACK) && (grant == GNT_A);
  assign b_ready         = (state == ST_ACK) && (grant == GNT_B);
  assign resp_err        = (state == ST_ACK) && abort && (grant != GNT_REC);
  assign rec_clear       = (state == ST_ACK) && (grant == GNT_REC);
  assign busy            = (state != ST_IDLE);
  assign recovery_active = rec_pending || (grant == GNT_REC);

endmodule

// File: doc/uart_cfg_ctrl.md
# uart_cfg_ctrl

Configuration controller for the UART receiver. It arbitrates register writes from two requesters (host port A, debug port B) and serialises them onto the UART's single c_valid/c_addr/c_data/c_ready configuration port. It also watches the UART error stream and issues an automatic recovery write after a run of consecutive bad frames. It sits between the system control logic and the UART instance, in the UART clock domain.

## Interface

Parameters:
- ERR_THRESH, 4: consecutive errored frames that trigger a recovery write (range 1..15).
- REC_ADDR, 4'b0101: config address written on recovery.
- REC_DATA, 8'h00: config data written on recovery.
- TIMEOUT, 64: maximum cycles to wait for c_ready before aborting a write.

Ports:
- clk, in, 1: single clock. All state is updated on the rising edge.
- rst, in, 1: reset. Asynchronous and active-low.
- a_valid, in, 1: port A write request.
- a_addr, in, 4: port A config address.
- a_data, in, 8: port A config data.
- a_ready, out, 1: one-cycle completion pulse for port A.
- b_valid, in, 1: port B write request.
- b_addr, in, 4: port B config address.
- b_data, in, 8: port B config data.
- b_ready, out, 1: one-cycle completion pulse for port B.
- resp_err, out, 1: high together with a_ready or b_ready when that write timed out.
- c_valid, out, 1: write strobe to the UART config port.
- c_addr, out, 4: address to the UART config port.
- c_data, out, 8: data to the UART config port.
- c_ready, in, 1: UART acceptance.
- error, in, 2: UART error code. 00 means none; any nonzero value is an error.
- valid_error, in, 1: qualifies `error`.
- valid_out, in, 1: UART delivered a good byte.
- err_count, out, 8: total errored frames, saturating at 255.
- recovery_active, out, 1: a recovery write is pending or in flight.
- busy, out, 1: FSM is not in IDLE.

## Operation

- FSM states: IDLE, ISSUE, ACK.
- IDLE: grant in this priority order:
  1. Pending recovery request.
  2. Between A and B, round-robin. The requester not served last wins a tie. After reset, A has priority.
  3. Latch the winner's addr/data into c_addr/c_data, set c_valid, go to ISSUE.
- ISSUE:
  - Hold c_valid, c_addr and c_data stable.
  - When c_valid && c_ready is sampled high, drop c_valid and go to ACK.
  - If the wait counter reaches TIMEOUT with no c_ready, drop c_valid, set the abort flag and go to ACK.
- ACK:
  - For an A or B grant, pulse that requester's ready for one cycle; resp_err equals the abort flag.
  - For a recovery grant, no requester pulse is produced; clear recovery pending.
  - Return to IDLE.
- Requesters hold valid/addr/data stable until they see their ready pulse. A request that drops valid early is undefined.
- Error monitor:
  - valid_error with a nonzero code increments err_count (saturating at 255) and the consecutive counter (4 bits, saturating at 15).
  - valid_out clears the consecutive counter.
  - If valid_error (with error) and valid_out occur in the same cycle, the error wins.
  - When the consecutive counter reaches ERR_THRESH and recovery is not already pending, set recovery pending and clear the consecutive counter.
  - Errors arriving while recovery is pending are still counted, but cannot queue a second recovery.
- recovery_active = recovery pending OR the current grant is a recovery grant.

## Timing

- Reset values, while rst is low: c_valid=0, c_addr=0, c_data=0, a_ready=0, b_ready=0, resp_err=0, err_count=0, recovery_active=0, busy=0. FSM is in IDLE, counters are 0, round-robin favours A.
- Reset asserted mid-transaction aborts it immediately. No ready pulse is produced and pending recovery is lost.
- Grant latency: request seen in IDLE at edge N gives c_valid high after edge N.
- If c_ready is already high in the first ISSUE cycle, the write is accepted at edge N+1. ACK occurs in cycle N+1..N+2, and the ready pulse is visible after edge N+1.
- Minimum 3 cycles per write. Back-to-back writes from the same port are therefore 3 cycles apart.
- Timeout: c_valid stays high for exactly TIMEOUT cycles, then ACK follows.
- Recovery pending is set on the edge after the threshold-reaching valid_error, and is granted at the next IDLE.

## Structure

- Shared uart_pkg:
  - FSM state enum.
  - Error code constants: ERR_NONE=00, ERR_PARITY=01, ERR_FRAME=10, ERR_OVERRUN=11.
  - Config address constants: 4'b0101 (parity mode), 4'b0110 (stop bits).
- One sub-module, uart_err_monitor: error/consecutive counters and the recovery-pending flag.
- The arbiter and FSM stay in the top level.

## Test plan

- Single write, c_ready tied high:
  - Stimulus: A writes addr 5, data 8'h03.
  - Response: c_valid high for exactly 1 cycle with 5/03; a_ready pulses 1 cycle later; resp_err=0.
- Contention, c_ready high:
  - Stimulus: A and B both valid continuously.
  - Response: grants alternate A, B, A, B starting with A; each port completes every 6 cycles.
- Timeout, TIMEOUT=64:
  - Stimulus: c_ready held low; B writes addr 6, data 01.
  - Response: c_valid high for 64 cycles, then b_ready=1 and resp_err=1.
- Recovery:
  - Stimulus: 4 valid_error pulses with code 01, with no valid_out in between.
  - Response: err_count=4; a write of 5/00 is issued with no a_ready or b_ready pulse; recovery_active clears after ACK.
  - Variant: a valid_out after the 3rd error means the 4th error produces no recovery.
- Reset mid-ISSUE:
  - Stimulus: rst low with c_ready held low.
  - Response: c_valid drops asynchronously; no ready pulse; err_count=0 after reset.
